// File: rtl/fpu_d_pkg.sv
// Shared constants and inter-stage records for the double-precision
// normalise/round/pack pipeline.
package fpu_d_pkg;

    localparam int MANT_W   = 105;
    localparam int EXP_W    = 13;
    localparam int SHIFT_W  = 7;
    localparam int EXP_BIAS = 1023;
    localparam int EXP_MAX  = 2 * EXP_BIAS + 1;
    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    // Registered operand plus its leading-zero count (S1 output).
    typedef struct packed {
        logic               valid;
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [MANT_W-1:0]  mant;
        logic [SHIFT_W-1:0] lzc;
        logic               nan;
        logic               inf;
        logic               mzero;
    } stage_t;

    // Normalised significand split into fraction and round bits (S2 output).
    typedef struct packed {
        logic        valid;
        logic        sign;
        logic [13:0] exp;
        logic [51:0] frac;
        logic        g;
        logic        r;
        logic        s;
        logic        nan;
        logic        inf;
        logic        mzero;
    } norm_t;

endpackage

// File: rtl/zeroenc.sv
// Index of the lowest set bit of i_data; fed a bit-reversed significand it
// yields the leading-zero count. Zero input gives 0.
module zeroenc #(
    parameter int iwidth     = 105,
    parameter int shiftwidth = 7
) (
    input  logic [iwidth-1:0]     i_data,
    output logic [shiftwidth-1:0] o_shift
);

    always_comb begin
        o_shift = '0;
        for (int i = iwidth - 1; i >= 0; i--) begin
            if (i_data[i]) begin
                o_shift = shiftwidth'(i);
            end
        end
    end

endmodule

// File: rtl/fpu_normround.sv
// Three-stage normalise / round-to-nearest-even / pack stage producing an
// IEEE-754 binary64 result with overflow, underflow (flush-to-zero) and inexact flags.
module fpu_normround
    import fpu_d_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_sign,
    input  logic [12:0]   i_exp,
    input  logic [104:0]  i_mant,
    input  logic          i_nan,
    input  logic          i_inf,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [63:0]   o_res,
    output logic          o_overflow,
    output logic          o_underflow,
    output logic          o_inexact
);

    // Handshake: an operand is taken when i_valid & o_ready; a result is
    // consumed when o_valid & i_ready. All stages move together on en, so a
    // stalled result holds its value and upstream stages hold theirs.
    logic en;

    stage_t s1_q, s1_d;
    norm_t  s2_q, s2_d;

    logic         out_valid_q;
    logic [63:0]  res_q;
    logic         ovf_q;
    logic         unf_q;
    logic         inx_q;

    logic [MANT_W-1:0]  mant_rev;
    logic [SHIFT_W-1:0] lzc;
    logic [MANT_W-2:0]  m;
    logic [13:0]        exp_ext;
    logic [13:0]        lzc_ext;

    logic               inc;
    logic [52:0]        sum;
    logic [13:0]        e_rnd;
    logic               ovf_cond;
    logic               unf_cond;
    logic [63:0]        res_d;
    logic               ovf_d;
    logic               unf_d;
    logic               inx_d;

    assign en      = !out_valid_q | i_ready;
    assign o_ready = en;

    // S1: register operand and leading-zero count
    always_comb begin
        mant_rev = '0;
        for (int i = 0; i < MANT_W; i++) begin
            mant_rev[i] = i_mant[MANT_W-1-i];
        end
    end

    zeroenc #(
        .iwidth     (MANT_W),
        .shiftwidth (SHIFT_W)
    ) u_zeroenc (
        .i_data  (mant_rev),
        .o_shift (lzc)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = i_valid;
        s1_d.sign  = i_sign;
        s1_d.exp   = i_exp;
        s1_d.mant  = i_mant;
        s1_d.lzc   = lzc;
        s1_d.nan   = i_nan;
        s1_d.inf   = i_inf;
        s1_d.mzero = (i_mant == '0);
    end

    // S2: normalise; the hidden bit lands on bit 104 and is dropped from m
    always_comb begin
        m       = (MANT_W-1)'(s1_q.mant << s1_q.lzc);
        exp_ext = {s1_q.exp[EXP_W-1], s1_q.exp};
        lzc_ext = {7'b0, s1_q.lzc};
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.exp   = exp_ext + 14'd1 - lzc_ext;
        s2_d.frac  = m[103:52];
        s2_d.g     = m[51];
        s2_d.r     = m[50];
        s2_d.s     = |m[49:0];
        s2_d.nan   = s1_q.nan;
        s2_d.inf   = s1_q.inf;
        s2_d.mzero = s1_q.mzero;
    end

    // S3: round to nearest-even, then pack with special-case priority
    always_comb begin
        inc      = s2_q.g & (s2_q.r | s2_q.s | s2_q.frac[0]);
        sum      = {1'b0, s2_q.frac} + {52'b0, inc};
        e_rnd    = s2_q.exp + {13'b0, sum[52]};
        ovf_cond = $signed(e_rnd) >= $signed(14'(EXP_MAX));
        unf_cond = $signed(s2_q.exp) <= $signed(14'd0);

        res_d = {s2_q.sign, e_rnd[10:0], sum[51:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = s2_q.g | s2_q.r | s2_q.s;

        if (s2_q.nan) begin
            res_d = CANON_NAN;
            inx_d = 1'b0;
        end else if (s2_q.inf) begin
            res_d = {s2_q.sign, 11'h7FF, 52'b0};
            inx_d = 1'b0;
        end else if (s2_q.mzero) begin
            res_d = {s2_q.sign, 63'b0};
            inx_d = 1'b0;
        end else if (ovf_cond) begin
            res_d = {s2_q.sign, 11'h7FF, 52'b0};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end else if (unf_cond) begin
            res_d = {s2_q.sign, 63'b0};
            unf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (en) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= s2_q.valid;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign o_valid     = out_valid_q;
    assign o_res       = res_q;
    assign o_overflow  = ovf_q & out_valid_q;
    assign o_underflow = unf_q & out_valid_q;
    assign o_inexact   = inx_q & out_valid_q;

endmodule
